// File: rtl/div_ctrl.sv
// div_ctrl: iterative restoring divider for DIV/DIVU with start/ready handshake,
// pipeline stall request and annul; result is {remainder, quotient}.
module div_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    signed_div_in,
  input  logic [DATA_WIDTH-1:0]   opdata1_in,
  input  logic [DATA_WIDTH-1:0]   opdata2_in,
  input  logic                    start_in,
  input  logic                    annul_in,
  output logic [2*DATA_WIDTH-1:0] result_out,
  output logic                    ready_out,
  output logic                    stall_req_out
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
  state_t state, next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0] dvd, dvs, rem, abs1, abs2, rem_nx, quo_nx, rem_fix, quo_fix;
  logic [W:0] partial, diff;
  logic sgn, s1, s2, go, ge, last;
  assign go = start_in && !annul_in;
  assign last = cnt == CNT_WIDTH'(W - 1);
  assign abs1 = (signed_div_in && opdata1_in[W-1]) ? -opdata1_in : opdata1_in;
  assign abs2 = (signed_div_in && opdata2_in[W-1]) ? -opdata2_in : opdata2_in;
  // one extra partial-remainder bit keeps unsigned divisors >= 2^(W-1) exact
  assign partial = {rem, dvd[W-1]};
  assign diff = partial - {1'b0, dvs};
  assign ge = !diff[W];
  assign rem_nx = ge ? diff[W-1:0] : partial[W-1:0];
  assign quo_nx = {dvd[W-2:0], ge};
  assign quo_fix = (sgn && (s1 ^ s2)) ? -quo_nx : quo_nx;
  assign rem_fix = (sgn && s1) ? -rem_nx : rem_nx;
  assign stall_req_out = rst_n && ((state == FREE && go) || state == ON || state == BY_ZERO);
  always_comb begin
    next_state = state;
    case (state)
      FREE:    next_state = go ? ((opdata2_in == '0) ? BY_ZERO : ON) : FREE;
      BY_ZERO: next_state = END;
      ON:      next_state = annul_in ? FREE : (last ? END : ON);
      END:     next_state = start_in ? END : FREE;
      default: next_state = FREE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FREE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      sgn <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      result_out <= '0;
      ready_out <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        FREE: if (go) begin
          dvd <= abs1;
          dvs <= abs2;
          rem <= '0;
          cnt <= '0;
          sgn <= signed_div_in;
          s1 <= opdata1_in[W-1];
          s2 <= opdata2_in[W-1];
        end
        BY_ZERO: begin
          result_out <= '0;
          ready_out <= 1'b1;
        end
        ON: if (annul_in) cnt <= '0;
        else begin
          dvd <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            result_out <= sgn ? {rem_fix, quo_fix} : {rem_nx, quo_nx};
            ready_out <= 1'b1;
          end
        end
        END: if (!start_in) begin
          result_out <= '0;
          ready_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed vectors with hand-computed results for div_ctrl.
module tb_div_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic signed_div_in = 1'b0, start_in = 1'b0, annul_in = 1'b0;
  logic [31:0] opdata1_in = '0, opdata2_in = '0;
  logic [63:0] result_out;
  logic ready_out, stall_req_out;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .signed_div_in(signed_div_in),
    .opdata1_in(opdata1_in), .opdata2_in(opdata2_in), .start_in(start_in),
    .annul_in(annul_in), .result_out(result_out), .ready_out(ready_out),
    .stall_req_out(stall_req_out)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // E0 counts as edge 1, so a normal divide reports 33 and divide-by-zero 2
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat = 0;
    logic stall_ok = 1'b1;
    logic [63:0] held;
    @(negedge clk);
    signed_div_in = sd; opdata1_in = a; opdata2_in = b; start_in = 1'b1;
    #1 chk({tag, " stall_at_req"}, 64'(stall_req_out), 64'd1);
    do begin
      @(posedge clk); #1 lat++;
      if (!ready_out && !stall_req_out) stall_ok = 1'b0;
    end while (!ready_out && lat < 100);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result_out, exp);
    chk({tag, " stall_wait"}, 64'(stall_ok), 64'd1);
    chk({tag, " stall_done"}, 64'(stall_req_out), 64'd0);
    held = result_out;
    repeat (3) @(posedge clk);
    #1 chk({tag, " hold_ready"}, 64'(ready_out), 64'd1);
    chk({tag, " hold_result"}, result_out, held);
    @(negedge clk) start_in = 1'b0;
    @(posedge clk); #1;
    chk({tag, " drop_ready"}, 64'(ready_out), 64'd0);
    chk({tag, " drop_result"}, result_out, 64'd0);
  endtask
  initial begin
    #1;
    chk("rst_ready", 64'(ready_out), 64'd0);
    chk("rst_result", result_out, 64'd0);
    chk("rst_stall", 64'(stall_req_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33);
    run_div("divu_big", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h00000001_00000001, 33);
    run_div("divu_zero", 1'b0, 32'h1234, 32'd0, 64'd0, 2);
    run_div("div_zero", 1'b1, 32'h1234, 32'd0, 64'd0, 2);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    // annul mid-divide: the flushed instruction also withdraws its start
    @(negedge clk);
    signed_div_in = 1'b0; opdata1_in = 32'd1000; opdata2_in = 32'd3; start_in = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk) begin annul_in = 1'b1; start_in = 1'b0; end
    @(posedge clk); #1;
    chk("annul_stall", 64'(stall_req_out), 64'd0);
    chk("annul_ready", 64'(ready_out), 64'd0);
    repeat (40) @(posedge clk);
    #1 chk("annul_no_ready", 64'(ready_out), 64'd0);
    @(negedge clk) begin start_in = 1'b1; annul_in = 1'b1; end
    #1 chk("start_annul_stall", 64'(stall_req_out), 64'd0);
    @(posedge clk); #1;
    chk("start_annul_stay", 64'(stall_req_out), 64'd0);
    @(negedge clk) begin start_in = 1'b0; annul_in = 1'b0; end
    run_div("divu_after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33);
    // async reset mid-divide, start still high while reset is held
    @(negedge clk);
    signed_div_in = 1'b0; opdata1_in = 32'd500; opdata2_in = 32'd9; start_in = 1'b1;
    repeat (21) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stall", 64'(stall_req_out), 64'd0);
    chk("arst_ready", 64'(ready_out), 64'd0);
    chk("arst_result", result_out, 64'd0);
    @(negedge clk) start_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_div("divu_after_rst", 1'b0, 32'd500, 32'd9, 64'h00000005_00000037, 33);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
